blwl_prog_ctrl: RTL

Programming controller that drives the bit-line/word-line bus of a memory-bank configuration array built from BL/WL-written SRAM cells. It accepts one row of configuration data per valid/ready handshake and writes rows 0 to NUM_WL-1 in order. For each row it presents the data on `bl`, pulses that row's `wl` with programmable setup, pulse and hold times, and flags completion when every row has been written. It sits between the bitstream loader and the configuration array, on the programming clock domain.

---
 rtl/blwl_prog_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/blwl_prog_ctrl.sv
// rtl/blwl_prog_ctrl.sv - BL/WL row programming controller for a configuration SRAM array
module blwl_prog_ctrl #(
  parameter int NUM_BL   = 8,
  parameter int NUM_WL   = 4,
  parameter int BL_SETUP = 1,
  parameter int WL_PULSE = 2,
  parameter int BL_HOLD  = 1
) (
  input  logic                                        prog_clk,
  input  logic                                        prog_rst_n,
  input  logic                                        start,
  input  logic [NUM_BL-1:0]                           din,
  input  logic                                        din_valid,
  output logic                                        din_ready,
  output logic [NUM_BL-1:0]                           bl,
  output logic [NUM_WL-1:0]                           wl,
  output logic [(NUM_WL > 1 ? $clog2(NUM_WL) : 1)-1:0] row_idx,
  output logic                                        busy,
  output logic                                        done
);

  localparam int RW    = (NUM_WL > 1) ? $clog2(NUM_WL) : 1;
  localparam int TMAX0 = (BL_SETUP > WL_PULSE) ? BL_SETUP : WL_PULSE;
  localparam int TMAX  = (TMAX0 > BL_HOLD) ? TMAX0 : BL_HOLD;
  // The timer only ever holds (phase length - 1).
  localparam int TW    = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [RW-1:0]       row_q, row_d;
  logic [NUM_BL-1:0]   bl_q, bl_d;
  logic [NUM_WL-1:0]   wl_q, wl_d;

  // State, timer, row counter and the registered bus drive; reset drops the bus at once.
  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      row_q   <= '0;
      bl_q    <= '0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      row_q   <= row_d;
      bl_q    <= bl_d;
      wl_q    <= wl_d;
    end
  end

  // Next-state sequencing; wl is derived from the next state so it is registered with it.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    row_d   = row_q;
    bl_d    = bl_q;
    wl_d    = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT_DATA;
          row_d   = '0;
          bl_d    = '0;
        end
      end
      S_WAIT_DATA: begin
        if (din_valid) begin
          bl_d    = din;
          timer_d = TW'(BL_SETUP - 1);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (timer_q == '0) begin
          timer_d = TW'(WL_PULSE - 1);
          state_d = S_PULSE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_PULSE: begin
        if (timer_q == '0) begin
          timer_d = TW'(BL_HOLD - 1);
          state_d = S_HOLD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_HOLD: begin
        if (timer_q == '0) begin
          if (row_q == RW'(NUM_WL - 1)) begin
            state_d = S_DONE;
          end else begin
            row_d   = row_q + RW'(1);
            state_d = S_WAIT_DATA;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_PULSE) begin
      wl_d = NUM_WL'(1) << row_d;
    end
  end

  assign bl        = bl_q;
  assign wl        = wl_q;
  assign row_idx   = row_q;
  assign din_ready = (state_q == S_WAIT_DATA);
  assign busy      = (state_q == S_WAIT_DATA) || (state_q == S_SETUP) ||
                     (state_q == S_PULSE) || (state_q == S_HOLD);
  assign done      = (state_q == S_DONE);

endmodule
